regfile_tagged: RTL

- Architectural register file with per-register rename tags.
- Sits downstream of the reorder buffer, which drives in-order commit writes into it.
- Also sits upstream of the decoder. The decoder reads source operand value/tag pairs and renames destination registers to newly allocated ROB tags.
- Provides a commit-to-read bypass so that operands read in the commit cycle see the committed value.

---
 rtl/regfile_tagged.sv | 122 ++++++++++++
 1 files changed

// File: rtl/regfile_tagged.sv
// Architectural register file with per-register rename tags, in-order commit
// writes, flush of speculative renames and a commit-to-read bypass.
module regfile_tagged #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5,
  parameter int TAG_W  = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_W-1:0]  rs1_addr,
  input  logic [REG_W-1:0]  rs2_addr,
  output logic [DATA_W-1:0] rs1_data,
  output logic [TAG_W-1:0]  rs1_tag,
  output logic [DATA_W-1:0] rs2_data,
  output logic [TAG_W-1:0]  rs2_tag,
  input  logic              rename_en,
  input  logic [REG_W-1:0]  rename_reg,
  input  logic [TAG_W-1:0]  rename_tag,
  input  logic              commit_en,
  input  logic [REG_W-1:0]  commit_reg,
  input  logic [DATA_W-1:0] commit_data,
  input  logic [TAG_W-1:0]  commit_tag,
  input  logic              flush,
  output logic [REG_W:0]    busy_count
);

  localparam int NUM_REGS = 1 << REG_W;
  localparam logic [TAG_W-1:0] TAG_FREE = {1'b1, {(TAG_W-1){1'b0}}};

  logic [DATA_W-1:0] data_q [NUM_REGS];
  logic [DATA_W-1:0] data_d [NUM_REGS];
  logic [TAG_W-1:0]  tag_q  [NUM_REGS];
  logic [TAG_W-1:0]  tag_d  [NUM_REGS];
  logic [REG_W:0]    busy_count_q;
  logic [REG_W:0]    busy_count_d;

  logic commit_ok;
  logic rename_ok;

  assign commit_ok = commit_en && (commit_reg != '0);
  assign rename_ok = rename_en && (rename_reg != '0) && !flush;

  // Next-state: commit first (data always, tag only if it is still the
  // committing producer), then flush or rename overrides the tag field.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    data_d       = data_q;
    tag_d        = tag_q;
    busy_count_d = '0;

    if (commit_ok) begin
      data_d[commit_reg] = commit_data;
      if (tag_q[commit_reg] == commit_tag) begin
        tag_d[commit_reg] = TAG_FREE;
      end
    end

    if (flush) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        tag_d[i] = TAG_FREE;
      end
    end else if (rename_ok) begin
      tag_d[rename_reg] = rename_tag;
    end

    // x0 is never renamed or committed, so only x1..xN-1 can be busy.
    for (int i = 1; i < NUM_REGS; i++) begin
      if (!tag_d[i][TAG_W-1]) begin
        busy_count_d = busy_count_d + (REG_W+1)'(1);
      end
    end
  end

  // NOTE: the storage array is reset explicitly because readers rely on
  // architectural zero values after reset; this forces flops, not RAM.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        data_q[i] <= '0;
        tag_q[i]  <= TAG_FREE;
      end
      busy_count_q <= '0;
    end else begin
      data_q       <= data_d;
      tag_q        <= tag_d;
      busy_count_q <= busy_count_d;
    end
  end

  assign busy_count = busy_count_q;

  // Read ports: x0 is hard-wired; a matching commit this cycle is bypassed.
  always_comb begin
    rs1_data = data_q[rs1_addr];
    rs1_tag  = tag_q[rs1_addr];
    if (rs1_addr == '0) begin
      rs1_data = '0;
      rs1_tag  = TAG_FREE;
    end else if (commit_en && (commit_reg == rs1_addr) &&
                 (tag_q[rs1_addr] == commit_tag)) begin
      rs1_data = commit_data;
      rs1_tag  = TAG_FREE;
    end
  end

  always_comb begin
    rs2_data = data_q[rs2_addr];
    rs2_tag  = tag_q[rs2_addr];
    if (rs2_addr == '0) begin
      rs2_data = '0;
      rs2_tag  = TAG_FREE;
    end else if (commit_en && (commit_reg == rs2_addr) &&
                 (tag_q[rs2_addr] == commit_tag)) begin
      rs2_data = commit_data;
      rs2_tag  = TAG_FREE;
    end
  end

endmodule
